// File: rtl/hash_out_mem_writer.sv
// Copies an N-word digest stream into a RAM starting at a base address,
// masking the unused high bits of the final word when the length is not word-aligned.
module hash_out_mem_writer #(
    parameter int unsigned IO_WIDTH      = 32,
    parameter int unsigned MAX_RAM_DEPTH = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [IO_WIDTH-1:0]              i_output_length,
    input  logic [$clog2(MAX_RAM_DEPTH)-1:0] i_base_addr,
    input  logic [IO_WIDTH-1:0]              i_data_in,
    input  logic                             i_data_in_valid,
    output logic                             o_data_in_ready,
    output logic                             o_wr_en,
    output logic [$clog2(MAX_RAM_DEPTH)-1:0] o_addr,
    output logic [IO_WIDTH-1:0]              o_data_out,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int unsigned AW = $clog2(MAX_RAM_DEPTH);
    localparam int unsigned RW = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
    localparam logic [IO_WIDTH-1:0] WORD_BITS = IO_WIDTH'(IO_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [IO_WIDTH-1:0] word_cnt;
    logic [IO_WIDTH-1:0] word_total;
    logic [RW-1:0]       rem;
    logic [AW-1:0]       addr_cnt;

    logic [IO_WIDTH-1:0] n_words_c;
    logic [RW-1:0]       rem_c;
    logic                last_word_c;
    logic [IO_WIDTH-1:0] wr_data_c;

    // Length decode on start, and last-word detection with partial-word masking
    always_comb begin
        rem_c       = RW'(i_output_length % WORD_BITS);
        n_words_c   = (i_output_length / WORD_BITS) + IO_WIDTH'(rem_c != '0);
        last_word_c = (word_cnt == (word_total - IO_WIDTH'(1)));
        wr_data_c   = i_data_in;
        if (last_word_c && (rem != '0)) begin
            wr_data_c = i_data_in & ((IO_WIDTH'(1) << rem) - IO_WIDTH'(1));
        end
    end

    // Control FSM with registered outputs; write strobe is a one-cycle pulse per transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            word_cnt        <= '0;
            word_total      <= '0;
            rem             <= '0;
            addr_cnt        <= '0;
            o_data_in_ready <= 1'b0;
            o_wr_en         <= 1'b0;
            o_addr          <= '0;
            o_data_out      <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        if (n_words_c == '0) begin
                            state           <= DONE;
                            o_done          <= 1'b1;
                            o_busy          <= 1'b0;
                            o_data_in_ready <= 1'b0;
                        end else begin
                            state           <= RUN;
                            word_cnt        <= '0;
                            word_total      <= n_words_c;
                            rem             <= rem_c;
                            addr_cnt        <= i_base_addr;
                            o_done          <= 1'b0;
                            o_busy          <= 1'b1;
                            o_data_in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (i_data_in_valid) begin
                        o_wr_en    <= 1'b1;
                        o_addr     <= addr_cnt;
                        o_data_out <= wr_data_c;
                        addr_cnt   <= addr_cnt + AW'(1);
                        word_cnt   <= word_cnt + IO_WIDTH'(1);
                        if (last_word_c) begin
                            state           <= LAST;
                            o_data_in_ready <= 1'b0;
                        end
                    end
                end
                LAST: begin
                    state  <= DONE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
                default: begin
                    state           <= IDLE;
                    o_busy          <= 1'b0;
                    o_done          <= 1'b0;
                    o_data_in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hash_out_mem_writer.md
HASH_OUT_MEM_WRITER -- requirements
Module: hash_out_mem_writer

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 32, stream and memory word width in bits.
REQ-002 SHALL have parameter MAX_RAM_DEPTH, default 64, depth of the destination RAM in words; AW = CLOG2(MAX_RAM_DEPTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, single-cycle start pulse.
REQ-006 SHALL have port i_output_length, input, IO_WIDTH, digest length in bits; sampled only on an accepted start.
REQ-007 SHALL have port i_base_addr, input, AW, first RAM address; sampled only on an accepted start.
REQ-008 SHALL have port i_data_in, input, IO_WIDTH, digest word from the upstream hash memory interface.
REQ-009 SHALL have port i_data_in_valid, input, 1, i_data_in is valid.
REQ-010 SHALL have port o_data_in_ready, output, 1, block accepts a word this cycle.
REQ-011 SHALL have port o_wr_en, output, 1, RAM write strobe.
REQ-012 SHALL have port o_addr, output, AW, RAM write address.
REQ-013 SHALL have port o_data_out, output, IO_WIDTH, RAM write data.
REQ-014 SHALL have port o_busy, output, 1, transfer in progress.
REQ-015 SHALL have port o_done, output, 1, transfer complete; level signal.

Function
REQ-016 SHALL implement states IDLE, RUN, LAST and DONE.
REQ-017 SHALL compute the word count N = ceil(i_output_length/IO_WIDTH) and remainder R = i_output_length mod IO_WIDTH on an accepted start.
REQ-018 SHALL accept i_start only in IDLE or DONE; a start in RUN or LAST is ignored.
REQ-019 On an accepted start with N>0: SHALL go to RUN, clear o_done, and load the address counter with i_base_addr and the word counter with 0.
REQ-020 On an accepted start with N=0: SHALL go directly to DONE on the next edge, with no o_wr_en pulse.
REQ-021 SHALL drive o_data_in_ready = 1 only in state RUN; the signal is decoded from state only (no combinational path from i_data_in_valid).
REQ-022 A transfer SHALL occur on an edge where i_data_in_valid and o_data_in_ready are both 1; i_data_in is ignored at all other times.
REQ-023 SHALL register each transferred word so that o_wr_en=1 in the following cycle, with o_addr = base + index (modulo 2^AW) and o_data_out = the word; latency is 1 cycle.
REQ-024 For the last word (index N-1) with R != 0: SHALL zero bits [IO_WIDTH-1:R] and pass bits [R-1:0] unchanged; all other words SHALL be written unmasked.
REQ-025 On transfer of word N-1: SHALL go RUN->LAST; LAST lasts exactly one cycle, during which the final o_wr_en is high.
REQ-026 SHALL go LAST->DONE on the next edge; o_done=1 from then until the next accepted start.
REQ-027 SHALL drive o_busy=1 in RUN and LAST, and 0 in IDLE and DONE.
REQ-028 SHALL drive o_wr_en=0 in every cycle not immediately following a transfer; back-to-back transfers SHALL produce back-to-back writes.
REQ-029 When i_data_in_valid is deasserted mid-stream: SHALL hold the counters, write no word, and stay in RUN indefinitely.
REQ-030 Address wrap: when base + index exceeds 2^AW-1, o_addr SHALL wrap modulo 2^AW; no error is flagged.
REQ-031 If i_start and i_data_in_valid are both high in IDLE or DONE: SHALL perform the start only; no word is transferred that cycle.

Reset
REQ-032 rst=0 SHALL immediately force state IDLE, and o_data_in_ready, o_wr_en, o_busy and o_done to 0; o_addr, o_data_out and the counters SHALL be forced to 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer; no further writes occur, and a new i_start is required after rst returns to 1.

Verification
REQ-034 Bench SHALL cover: length 128, base 0, valid held high with words A0..A3 -> writes at addr 0..3 in 4 consecutive cycles, each 1 cycle after its transfer; o_done rises 2 cycles after the last transfer.
REQ-035 Bench SHALL cover: length 100 (N=4, R=4), last word 0xFFFFFFFF -> 4th write data 0x0000000F.
REQ-036 Bench SHALL cover: length 0 -> no o_wr_en; o_done=1 one cycle after start; o_busy never asserted.
REQ-037 Bench SHALL cover: length 128, i_data_in_valid toggling every other cycle -> 4 writes, addresses contiguous, o_wr_en gaps mirror the valid gaps.
REQ-038 Bench SHALL cover: MAX_RAM_DEPTH 64, base 62, length 128 -> write addresses 62, 63, 0, 1.
REQ-039 Bench SHALL cover: rst=0 after the 2nd transfer -> outputs 0 immediately, no 3rd write; a new start with length 64 then completes normally.
